// File: rtl/life_sequencer.sv
// Game of Life generation scheduler: raster-scans the current cell bank, applies
// Conway's rule per cell, writes the idle bank, plots changed cells and serves cell loads.
module life_sequencer #(
   parameter int         WIDTH        = 160,
   parameter int         HEIGHT       = 120,
   parameter logic [2:0] ALIVE_COLOUR = 3'b010,
   parameter logic [2:0] DEAD_COLOUR  = 3'b000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        run,
   input  logic        step,
   input  logic        tick,
   input  logic        load_req,
   input  logic [7:0]  load_x,
   input  logic [6:0]  load_y,
   output logic        load_ack,
   output logic        rd_en,
   output logic        rd_bank,
   output logic [14:0] rd_addr,
   input  logic        rd_data,
   output logic        wr_en,
   output logic        wr_bank,
   output logic [14:0] wr_addr,
   output logic        wr_data,
   output logic        plot,
   output logic [7:0]  plot_x,
   output logic [6:0]  plot_y,
   output logic [2:0]  plot_colour,
   output logic        busy,
   output logic [15:0] generation
);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_TICK, FETCH, EVAL, NEXT, SWAP} state_t;

   state_t      state_q, state_d;
   logic [7:0]  x_q, x_d;
   logic [6:0]  y_q, y_d;
   logic [3:0]  k_q, k_d;
   logic [3:0]  count_q, count_d;
   logic        centre_q, centre_d;
   logic        data_vld_q;
   logic        cur_bank_q, cur_bank_d;
   logic [15:0] generation_q, generation_d;

   logic        load_ack_q, load_ack_d;
   logic        rd_en_q, rd_en_d, rd_bank_q, rd_bank_d;
   logic [14:0] rd_addr_q, rd_addr_d;
   logic        wr_en_q, wr_en_d, wr_bank_q, wr_bank_d, wr_data_q, wr_data_d;
   logic [14:0] wr_addr_q, wr_addr_d;
   logic        plot_q, plot_d;
   logic [7:0]  plot_x_q, plot_x_d;
   logic [6:0]  plot_y_q, plot_y_d;
   logic [2:0]  plot_colour_q, plot_colour_d;
   logic        busy_q, busy_d;

   logic        load_go, rd_bit, next_cell;
   logic [3:0]  count_full;
   logic signed [1:0] dx, dy;
   logic signed [9:0] nx, ny;

   // Neighbour offsets in fetch order: centre, then the row above, same row, row below.
   function automatic logic signed [1:0] off_dx(input logic [3:0] k);
      case (k)
         4'd1, 4'd4, 4'd6: off_dx = -2'sd1;
         4'd3, 4'd5, 4'd8: off_dx = 2'sd1;
         default:          off_dx = 2'sd0;
      endcase
   endfunction

   function automatic logic signed [1:0] off_dy(input logic [3:0] k);
      case (k)
         4'd1, 4'd2, 4'd3: off_dy = -2'sd1;
         4'd6, 4'd7, 4'd8: off_dy = 2'sd1;
         default:          off_dy = 2'sd0;
      endcase
   endfunction

   // The ack flop guards against re-sampling a request the requester drops one cycle late.
   assign load_go    = load_req & ~load_ack_q;
   assign rd_bit     = data_vld_q & rd_data;
   assign count_full = count_q + {3'b000, rd_bit};
   assign next_cell  = (count_full == 4'd3) | (centre_q & (count_full == 4'd2));

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      k_d           = k_q;
      count_d       = count_q;
      centre_d      = centre_q;
      cur_bank_d    = cur_bank_q;
      generation_d  = generation_q;
      load_ack_d    = 1'b0;
      wr_en_d       = 1'b0;
      wr_bank_d     = 1'b0;
      wr_addr_d     = '0;
      wr_data_d     = 1'b0;
      plot_d        = 1'b0;
      plot_x_d      = '0;
      plot_y_d      = '0;
      plot_colour_d = '0;
      case (state_q)
         IDLE: begin
            if (load_go) state_d = LOAD;
            else if (step) begin
               state_d = FETCH; x_d = '0; y_d = '0; k_d = '0;
            end else if (run) state_d = WAIT_TICK;
         end
         WAIT_TICK: begin
            if (load_go) state_d = LOAD;
            else if (tick) begin
               state_d = FETCH; x_d = '0; y_d = '0; k_d = '0;
            end else if (!run) state_d = IDLE;
         end
         LOAD: begin
            load_ack_d    = 1'b1;
            wr_en_d       = 1'b1;
            wr_bank_d     = cur_bank_q;
            wr_addr_d     = 15'(load_y) * 15'(WIDTH) + 15'(load_x);
            wr_data_d     = 1'b1;
            plot_d        = 1'b1;
            plot_x_d      = load_x;
            plot_y_d      = load_y;
            plot_colour_d = ALIVE_COLOUR;
            state_d       = IDLE;
         end
         FETCH: begin
            // Read data lags its strobe by one cycle, so step k sees offset k-1.
            if (k_q == 4'd0) begin
               count_d = '0; centre_d = 1'b0;
            end else if (k_q == 4'd1) centre_d = rd_bit;
            else count_d = count_full;
            if (k_q == 4'd8) state_d = EVAL;
            else k_d = k_q + 4'd1;
         end
         EVAL: begin
            wr_en_d   = 1'b1;
            wr_bank_d = ~cur_bank_q;
            wr_addr_d = 15'(y_q) * 15'(WIDTH) + 15'(x_q);
            wr_data_d = next_cell;
            if (next_cell != centre_q) begin
               plot_d        = 1'b1;
               plot_x_d      = x_q;
               plot_y_d      = y_q;
               plot_colour_d = next_cell ? ALIVE_COLOUR : DEAD_COLOUR;
            end
            state_d = NEXT;
         end
         NEXT: begin
            k_d = '0;
            if (x_q == 8'(WIDTH - 1)) begin
               x_d = '0;
               if (y_q == 7'(HEIGHT - 1)) begin
                  y_d = '0; state_d = SWAP;
               end else begin
                  y_d = y_q + 7'd1; state_d = FETCH;
               end
            end else begin
               x_d = x_q + 8'd1; state_d = FETCH;
            end
         end
         SWAP: begin
            cur_bank_d   = ~cur_bank_q;
            generation_d = generation_q + 16'd1;
            state_d      = run ? WAIT_TICK : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read strobe and busy are decoded from the next state so the registered
   // outputs line up with the FETCH cycle they belong to.
   always_comb begin
      rd_en_d   = 1'b0;
      rd_bank_d = 1'b0;
      rd_addr_d = '0;
      dx        = off_dx(k_d);
      dy        = off_dy(k_d);
      nx        = $signed({2'b00, x_d}) + $signed({{8{dx[1]}}, dx});
      ny        = $signed({3'b000, y_d}) + $signed({{8{dy[1]}}, dy});
      busy_d    = (state_d == FETCH) || (state_d == EVAL) || (state_d == NEXT) || (state_d == SWAP);
      if ((state_d == FETCH) && !nx[9] && !ny[9] && (nx < 10'(WIDTH)) && (ny < 10'(HEIGHT))) begin
         rd_en_d   = 1'b1;
         rd_bank_d = cur_bank_q;
         rd_addr_d = 15'(ny[6:0]) * 15'(WIDTH) + 15'(nx[7:0]);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= IDLE;
         x_q           <= '0;
         y_q           <= '0;
         k_q           <= '0;
         count_q       <= '0;
         centre_q      <= 1'b0;
         data_vld_q    <= 1'b0;
         cur_bank_q    <= 1'b0;
         generation_q  <= '0;
         load_ack_q    <= 1'b0;
         rd_en_q       <= 1'b0;
         rd_bank_q     <= 1'b0;
         rd_addr_q     <= '0;
         wr_en_q       <= 1'b0;
         wr_bank_q     <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= 1'b0;
         plot_q        <= 1'b0;
         plot_x_q      <= '0;
         plot_y_q      <= '0;
         plot_colour_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         k_q           <= k_d;
         count_q       <= count_d;
         centre_q      <= centre_d;
         data_vld_q    <= rd_en_q;
         cur_bank_q    <= cur_bank_d;
         generation_q  <= generation_d;
         load_ack_q    <= load_ack_d;
         rd_en_q       <= rd_en_d;
         rd_bank_q     <= rd_bank_d;
         rd_addr_q     <= rd_addr_d;
         wr_en_q       <= wr_en_d;
         wr_bank_q     <= wr_bank_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         plot_q        <= plot_d;
         plot_x_q      <= plot_x_d;
         plot_y_q      <= plot_y_d;
         plot_colour_q <= plot_colour_d;
         busy_q        <= busy_d;
      end
   end

   assign load_ack    = load_ack_q;
   assign rd_en       = rd_en_q;
   assign rd_bank     = rd_bank_q;
   assign rd_addr     = rd_addr_q;
   assign wr_en       = wr_en_q;
   assign wr_bank     = wr_bank_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign plot        = plot_q;
   assign plot_x      = plot_x_q;
   assign plot_y      = plot_y_q;
   assign plot_colour = plot_colour_q;
   assign busy        = busy_q;
   assign generation  = generation_q;

endmodule
